fetch_stage: RTL and testbench

- Y86-64 pipeline fetch stage, directly upstream of the decode pipeline register.
- Holds the F_predPC register and selects the fetch PC from predPC or a redirect source (mispredicted jump, ret).
- Splits and aligns the 10-byte instruction window. Produces f_icode/f_ifun/f_rA/f_rB/f_valC/f_valP/f_stat plus the hlt, imem_err and instr_valid flags the decode register consumes.

---
 rtl/y86_pkg.sv | 28 ++
 rtl/instr_align.sv | 52 +++++
 rtl/fetch_stage.sv | 123 ++++++++++++
 tb/tb_fetch_stage.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes and the "no register" id.
package y86_pkg;

    // Instruction codes (byte0 high nibble)
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] FNONE = 4'h0;
    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [3:0] {
        SAOK = 4'd1,
        SHLT = 4'd2,
        SADR = 4'd3,
        SINS = 4'd4
    } stat_e;

endpackage

// File: rtl/instr_align.sv
// Combinational split of the 10-byte instruction window.
// Ports:
//   window      in  80  bytes pc..pc+9, byte 0 in bits [7:0]
//   icode/ifun  out 4   byte0 high/low nibble
//   ra/rb       out 4   byte1 nibbles when register ids are present, else RNONE
//   valc        out 64  little-endian constant word, else 0
//   need_regids out 1   instruction carries a register-id byte
//   need_valc   out 1   instruction carries an 8-byte constant
module instr_align
    import y86_pkg::*;
(
    input  logic [79:0] window,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  ra,
    output logic [3:0]  rb,
    output logic [63:0] valc,
    output logic        need_regids,
    output logic        need_valc
);

    always_comb begin
        icode = window[7:4];
        ifun  = window[3:0];

        need_regids = 1'b0;
        need_valc   = 1'b0;
        case (icode)
            IRRMOVQ, IOPQ, IPUSHQ, IPOPQ: need_regids = 1'b1;
            IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
                need_regids = 1'b1;
                need_valc   = 1'b1;
            end
            IJXX, ICALL: need_valc = 1'b1;
            default: ;
        endcase

        ra = RNONE;
        rb = RNONE;
        if (need_regids) begin
            ra = window[15:12];
            rb = window[11:8];
        end

        // The constant starts right after the optional register byte.
        valc = 64'h0;
        if (need_valc) begin
            valc = need_regids ? window[79:16] : window[71:8];
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: PC select, instruction split, valP, status and the F_predPC register.
// Optional macro FETCH_PERF_EN adds saturating perf counters (perf_fetched, perf_stall,
// perf_redirect).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   F_stall                  hold F_predPC
//   M_icode/M_Cnd/M_valA     mispredicted-jump redirect source
//   W_icode/W_valM           ret redirect source
//   imem_addr, imem_data     instruction window fetch (addr == f_pc)
//   imem_err_in              external memory error
//   f_*                      fetched instruction fields and status
//   hlt, imem_err            halt fetched, address error
//   instr_valid              HIGH when icode is not recognised
//   F_predPC                 predicted-PC register
module fetch_stage
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int unsigned IMEM_SIZE = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        F_stall,
    input  logic [3:0]  M_icode,
    input  logic        M_Cnd,
    input  logic [63:0] M_valA,
    input  logic [3:0]  W_icode,
    input  logic [63:0] W_valM,
    output logic [63:0] imem_addr,
    input  logic [79:0] imem_data,
    input  logic        imem_err_in,
    output logic [63:0] f_pc,
    output logic [3:0]  f_icode,
    output logic [3:0]  f_ifun,
    output logic [3:0]  f_rA,
    output logic [3:0]  f_rB,
    output logic [63:0] f_valC,
    output logic [63:0] f_valP,
    output logic [3:0]  f_stat,
    output logic        hlt,
    output logic        imem_err,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_redirect,
`endif
    output logic        instr_valid,
    output logic [63:0] F_predPC
);

    logic [3:0]  raw_icode;
    logic [3:0]  raw_ifun;
    logic        need_regids;
    logic        need_valc;
    logic        sel_m;
    logic        sel_w;
    logic [63:0] ilen;
    logic [64:0] fetch_end;
    logic [63:0] pred_pc;

    instr_align u_align (
        .window      (imem_data),
        .icode       (raw_icode),
        .ifun        (raw_ifun),
        .ra          (f_rA),
        .rb          (f_rB),
        .valc        (f_valC),
        .need_regids (need_regids),
        .need_valc   (need_valc)
    );

    always_comb begin
        sel_m = (M_icode == IJXX) && !M_Cnd;
        sel_w = !sel_m && (W_icode == IRET);
        if (sel_m)      f_pc = M_valA;
        else if (sel_w) f_pc = W_valM;
        else            f_pc = F_predPC;
        imem_addr = f_pc;

        ilen   = 64'd1 + {63'd0, need_regids} + (need_valc ? 64'd8 : 64'd0);
        f_valP = f_pc + ilen;

        // 65-bit sum so a window wrapping past 2^64 still counts as out of range.
        fetch_end = {1'b0, f_pc} + {1'b0, ilen};
        imem_err  = imem_err_in || (fetch_end > 65'(IMEM_SIZE));

        f_icode = imem_err ? INOP  : raw_icode;
        f_ifun  = imem_err ? FNONE : raw_ifun;

        instr_valid = f_icode > IPOPQ;
        hlt         = f_icode == IHALT;

        if (imem_err)         f_stat = SADR;
        else if (instr_valid) f_stat = SINS;
        else if (hlt)         f_stat = SHLT;
        else                  f_stat = SAOK;

        pred_pc = ((f_icode == IJXX) || (f_icode == ICALL)) ? f_valC : f_valP;
    end

    always_ff @(posedge clk) begin
        if (rst)           F_predPC <= RESET_PC;
        else if (!F_stall) F_predPC <= pred_pc;
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched  <= 32'd0;
            perf_stall    <= 32'd0;
            perf_redirect <= 32'd0;
        end else begin
            if (!F_stall && f_stat == SAOK && perf_fetched != 32'hFFFF_FFFF)
                perf_fetched <= perf_fetched + 32'd1;
            if (F_stall && perf_stall != 32'hFFFF_FFFF)
                perf_stall <= perf_stall + 32'd1;
            if ((sel_m || sel_w) && perf_redirect != 32'hFFFF_FFFF)
                perf_redirect <= perf_redirect + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with hand-computed expectations.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        F_stall;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valA;
    logic [3:0]  W_icode;
    logic [63:0] W_valM;
    logic [63:0] imem_addr;
    logic [79:0] imem_data;
    logic        imem_err_in;
    logic [63:0] f_pc;
    logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
    logic [63:0] f_valC, f_valP;
    logic [3:0]  f_stat;
    logic        hlt, imem_err, instr_valid;
    logic [63:0] F_predPC;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stall, perf_redirect;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC  (64'h100),
        .IMEM_SIZE (4096)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .F_stall     (F_stall),
        .M_icode     (M_icode),
        .M_Cnd       (M_Cnd),
        .M_valA      (M_valA),
        .W_icode     (W_icode),
        .W_valM      (W_valM),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .imem_err_in (imem_err_in),
        .f_pc        (f_pc),
        .f_icode     (f_icode),
        .f_ifun      (f_ifun),
        .f_rA        (f_rA),
        .f_rB        (f_rB),
        .f_valC      (f_valC),
        .f_valP      (f_valP),
        .f_stat      (f_stat),
        .hlt         (hlt),
        .imem_err    (imem_err),
`ifdef FETCH_PERF_EN
        .perf_fetched  (perf_fetched),
        .perf_stall    (perf_stall),
        .perf_redirect (perf_redirect),
`endif
        .instr_valid (instr_valid),
        .F_predPC    (F_predPC)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Window with optional register byte followed by the constant.
    function automatic logic [79:0] win(input logic [7:0] b0, input logic [7:0] b1,
                                        input logic [63:0] c, input bit regs);
        if (regs) return {c, b1, b0};
        return {8'h00, c, b0};
    endfunction

    // Advance one clock; sampling happens on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; F_stall = 1'b1;
        M_icode = 4'h0; M_Cnd = 1'b0; M_valA = 64'h0;
        W_icode = 4'h0; W_valM = 64'h0;
        imem_data = win(8'h10, 8'h00, 64'h0, 1'b0);
        imem_err_in = 1'b0;

        // Reset wins over stall
        tick();
        check("reset_predpc", F_predPC, 64'h100);
        check("reset_fpc", f_pc, 64'h100);
        check("reset_addr", imem_addr, 64'h100);
        rst = 1'b0; F_stall = 1'b0;

        // irmovq $0xA, %rdx
        imem_data = win(8'h30, 8'hF2, 64'hA, 1'b1);
        #1;
        check("irmovq_icode", {60'd0, f_icode}, 64'h3);
        check("irmovq_ra", {60'd0, f_rA}, 64'hF);
        check("irmovq_rb", {60'd0, f_rB}, 64'h2);
        check("irmovq_valc", f_valC, 64'hA);
        check("irmovq_valp", f_valP, 64'h10A);
        check("irmovq_stat", {60'd0, f_stat}, 64'h1);
        tick();
        check("irmovq_pred", F_predPC, 64'h10A);

        // jmp 0x200
        imem_data = win(8'h70, 8'h00, 64'h200, 1'b0);
        #1;
        check("jxx_valc", f_valC, 64'h200);
        check("jxx_valp", f_valP, 64'h113);
        check("jxx_rb", {60'd0, f_rB}, 64'hF);
        tick();
        check("jxx_pred", F_predPC, 64'h200);

        // Redirect priority
        imem_data = win(8'h10, 8'h00, 64'h0, 1'b0);
        M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 64'h109;
        W_icode = 4'h9; W_valM = 64'h300;
        #1;
        check("mispredict_wins", f_pc, 64'h109);
        check("mispredict_valp", f_valP, 64'h10A);
        M_icode = 4'h0;
        #1;
        check("ret_select", f_pc, 64'h300);
        M_icode = 4'h7; M_Cnd = 1'b1; W_icode = 4'h0;
        #1;
        check("taken_no_redirect", f_pc, 64'h200);
        M_icode = 4'h0; M_Cnd = 1'b0;

        // Stall holds F_predPC while f_pc still follows redirects
        F_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold", F_predPC, 64'h200);
        end
        W_icode = 4'h9; W_valM = 64'h480;
        #1;
        check("stall_redirect", f_pc, 64'h480);
        W_icode = 4'h0;
        F_stall = 1'b0;
        tick();
        check("unstall_pred", F_predPC, 64'h201);

        // Address error at the top of memory
        M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 64'd4091;
        imem_data = win(8'h30, 8'hF2, 64'hA, 1'b1);
        #1;
        check("adr_err", {63'd0, imem_err}, 64'h1);
        check("adr_stat", {60'd0, f_stat}, 64'h3);
        check("adr_icode", {60'd0, f_icode}, 64'h1);
        check("adr_ifun", {60'd0, f_ifun}, 64'h0);
        M_valA = 64'd4086;
        #1;
        check("edge_no_err", {63'd0, imem_err}, 64'h0);
        check("edge_stat", {60'd0, f_stat}, 64'h1);
        imem_err_in = 1'b1;
        #1;
        check("ext_err", {60'd0, f_stat}, 64'h3);
        imem_err_in = 1'b0;
        M_icode = 4'h0;

        // Invalid instruction; predPC still falls through
        imem_data = win(8'hC0, 8'h00, 64'h0, 1'b0);
        #1;
        check("ins_valid_flag", {63'd0, instr_valid}, 64'h1);
        check("ins_stat", {60'd0, f_stat}, 64'h4);
        tick();
        check("ins_pred", F_predPC, 64'h202);

        // Halt
        imem_data = win(8'h00, 8'h00, 64'h0, 1'b0);
        #1;
        check("hlt_flag", {63'd0, hlt}, 64'h1);
        check("hlt_stat", {60'd0, f_stat}, 64'h2);

        // Reset mid-stall
        F_stall = 1'b1; rst = 1'b1;
        tick();
        check("rst_mid_stall", F_predPC, 64'h100);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
